io_uart: RTL and testbench

//  Memory-mapped UART that answers CPU accesses to the I/O page (address high byte 8'hFE).

---
 rtl/io_pkg.sv | 54 +++++
 rtl/io_uart_sync_fifo.sv | 44 ++++
 rtl/io_uart.sv | 215 +++++++++++++++++++++
 tb/tb_io_uart.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS layout,
// serial FSM states and the per-direction shifter record.
package io_pkg;

  localparam logic [7:0] REG_DATA   = 8'd0;
  localparam logic [7:0] REG_STATUS = 8'd1;

  localparam int STAT_RXAV   = 0;
  localparam int STAT_TXFULL = 1;
  localparam int STAT_OVR    = 2;
  localparam int STAT_TXIDLE = 3;
  localparam int STAT_FERR   = 4;

  localparam logic [1:0] FSM_IDLE  = 2'd0;
  localparam logic [1:0] FSM_START = 2'd1;
  localparam logic [1:0] FSM_DATA  = 2'd2;
  localparam logic [1:0] FSM_STOP  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = FSM_IDLE,
    ST_START = FSM_START,
    ST_DATA  = FSM_DATA,
    ST_STOP  = FSM_STOP
  } serState_t;

  // Whole shifter state in one record so a checker can bind to a single signal.
  typedef struct packed {
    serState_t   state;
    logic [15:0] baudCnt;
    logic [2:0]  bitIdx;
    logic [7:0]  shift;
  } serCore_t;

  localparam serCore_t SER_CORE_RESET = '{
    state:   ST_IDLE,
    baudCnt: 16'd0,
    bitIdx:  3'd0,
    shift:   8'd0
  };

  function automatic logic [7:0] packStatus(input logic rxAv, input logic txFull,
                                            input logic ovr, input logic txIdle,
                                            input logic ferr);
    logic [7:0] s;
    s              = 8'd0;
    s[STAT_RXAV]   = rxAv;
    s[STAT_TXFULL] = txFull;
    s[STAT_OVR]    = ovr;
    s[STAT_TXIDLE] = txIdle;
    s[STAT_FERR]   = ferr;
    return s;
  endfunction

endpackage

// File: rtl/io_uart_sync_fifo.sv
// Single-clock FIFO with (AW+1)-bit wrapping pointers; a push into a full FIFO
// is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_resetN,
  input  logic             push,
  input  logic [WIDTH-1:0] wrData,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [2**AW];
  logic             doPush;
  logic             doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign head   = mem[rdPtr[AW-1:0]];
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART on the CPU I/O page: DATA/STATUS registers, TX and RX
// FIFOs, a TX shifter and an RX mid-bit sampler.
// Bus handshake: a read is a qualified cycle with i_ioNOE low (data valid
// combinationally, side effects on the closing edge); a write is a qualified
// cycle with i_ioNWE low, taken on the closing edge; there is no back-pressure.
module io_uart
  import io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         CLK_DIV   = 16,
  parameter int         FIFO_AW   = 3
) (
  input  logic       i_clk,
  input  logic       i_resetN,
  input  logic       i_ioSelect,
  input  logic [7:0] i_ioAddress,
  input  logic       i_ioNOE,
  input  logic       i_ioNWE,
  input  logic [7:0] i_bus,
  output logic [7:0] o_bus,
  output logic       o_busNOE,
  input  logic       i_rx,
  output logic       o_tx
);

  localparam logic [7:0]  DATA_ADDR   = BASE_ADDR + REG_DATA;
  localparam logic [7:0]  STATUS_ADDR = BASE_ADDR + REG_STATUS;
  localparam logic [15:0] BIT_LAST    = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST   = 16'(CLK_DIV / 2 - 1);

  logic       hitData, hitStatus;
  logic       readData, readStatus, cpuWrite;
  logic       txFull, txEmpty, txPop, txBit, txIdle;
  logic [7:0] txHead;
  logic       rxFull, rxEmpty, rxPop, rxPushReq, ferrSet, ovrSet;
  logic [7:0] rxHead, statusByte;
  logic       rxMeta, rxSync, rxPrev;
  logic       ovr, ferr;
  serCore_t   txCore, txNext;
  serCore_t   rxCore, rxNext;

  // ---------------- CPU access decode ----------------
  assign hitData    = i_ioSelect & i_resetN & (i_ioAddress == DATA_ADDR);
  assign hitStatus  = i_ioSelect & i_resetN & (i_ioAddress == STATUS_ADDR);
  assign readData   = hitData & ~i_ioNOE;
  assign readStatus = hitStatus & ~i_ioNOE;
  assign cpuWrite   = hitData & ~i_ioNWE;
  assign rxPop      = readData & ~rxEmpty;

  assign txIdle     = txEmpty & (txCore.state == ST_IDLE);
  assign statusByte = packStatus(~rxEmpty, txFull, ovr, txIdle, ferr);

  always_comb begin
    o_bus = 8'h00;
    if (readData)        o_bus = rxEmpty ? 8'h00 : rxHead;
    else if (readStatus) o_bus = statusByte;
  end

  assign o_busNOE = ~(readData | readStatus);

  sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) txFifo (
    .i_clk    (i_clk),
    .i_resetN (i_resetN),
    .push     (cpuWrite),
    .wrData   (i_bus),
    .pop      (txPop),
    .full     (txFull),
    .empty    (txEmpty),
    .head     (txHead)
  );

  sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) rxFifo (
    .i_clk    (i_clk),
    .i_resetN (i_resetN),
    .push     (rxPushReq),
    .wrData   (rxCore.shift),
    .pop      (rxPop),
    .full     (rxFull),
    .empty    (rxEmpty),
    .head     (rxHead)
  );

  // ---------------- TX shifter ----------------
  always_comb begin
    txNext = txCore;
    txPop  = 1'b0;
    txBit  = 1'b1;
    case (txCore.state)
      ST_IDLE: begin
        if (!txEmpty) begin
          txNext.state   = ST_START;
          txNext.baudCnt = 16'd0;
          txNext.shift   = txHead;
          txPop          = 1'b1;
        end
      end
      ST_START: begin
        txBit = 1'b0;
        if (txCore.baudCnt == BIT_LAST) begin
          txNext.state   = ST_DATA;
          txNext.baudCnt = 16'd0;
          txNext.bitIdx  = 3'd0;
        end else begin
          txNext.baudCnt = txCore.baudCnt + 16'd1;
        end
      end
      ST_DATA: begin
        txBit = txCore.shift[0];
        if (txCore.baudCnt == BIT_LAST) begin
          txNext.baudCnt = 16'd0;
          txNext.shift   = {1'b0, txCore.shift[7:1]};
          txNext.bitIdx  = txCore.bitIdx + 3'd1;
          if (txCore.bitIdx == 3'd7) txNext.state = ST_STOP;
        end else begin
          txNext.baudCnt = txCore.baudCnt + 16'd1;
        end
      end
      ST_STOP: begin
        txBit = 1'b1;
        if (txCore.baudCnt == BIT_LAST) begin
          txNext.baudCnt = 16'd0;
          // Chain straight into the next start bit so frames stay contiguous.
          if (!txEmpty) begin
            txNext.state = ST_START;
            txNext.shift = txHead;
            txPop        = 1'b1;
          end else begin
            txNext.state = ST_IDLE;
          end
        end else begin
          txNext.baudCnt = txCore.baudCnt + 16'd1;
        end
      end
      default: txNext = SER_CORE_RESET;
    endcase
  end

  // o_tx is registered so the line is glitch-free; it trails the FSM by one cycle.
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      txCore <= SER_CORE_RESET;
      o_tx   <= 1'b1;
    end else begin
      txCore <= txNext;
      o_tx   <= txBit;
    end
  end

  // ---------------- RX sampler ----------------
  always_comb begin
    rxNext    = rxCore;
    rxPushReq = 1'b0;
    ferrSet   = 1'b0;
    case (rxCore.state)
      ST_IDLE: begin
        if (rxPrev & ~rxSync) begin
          rxNext.state   = ST_START;
          rxNext.baudCnt = 16'd0;
        end
      end
      ST_START: begin
        if (rxCore.baudCnt == HALF_LAST) begin
          rxNext.baudCnt = 16'd0;
          rxNext.bitIdx  = 3'd0;
          rxNext.state   = rxSync ? ST_IDLE : ST_DATA;
        end else begin
          rxNext.baudCnt = rxCore.baudCnt + 16'd1;
        end
      end
      ST_DATA: begin
        if (rxCore.baudCnt == BIT_LAST) begin
          rxNext.baudCnt = 16'd0;
          rxNext.shift   = {rxSync, rxCore.shift[7:1]};
          rxNext.bitIdx  = rxCore.bitIdx + 3'd1;
          if (rxCore.bitIdx == 3'd7) rxNext.state = ST_STOP;
        end else begin
          rxNext.baudCnt = rxCore.baudCnt + 16'd1;
        end
      end
      ST_STOP: begin
        if (rxCore.baudCnt == BIT_LAST) begin
          rxNext.baudCnt = 16'd0;
          rxNext.state   = ST_IDLE;
          rxPushReq      = rxSync;
          ferrSet        = ~rxSync;
        end else begin
          rxNext.baudCnt = rxCore.baudCnt + 16'd1;
        end
      end
      default: rxNext = SER_CORE_RESET;
    endcase
  end

  // A same-edge DATA read frees a slot, so only a truly full FIFO overruns.
  assign ovrSet = rxPushReq & rxFull & ~rxPop;

  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
      rxCore <= SER_CORE_RESET;
      ovr    <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      rxMeta <= i_rx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
      rxCore <= rxNext;
      ovr    <= ovrSet | (ovr & ~readStatus);
      ferr   <= ferrSet | (ferr & ~readStatus);
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Directed bench for io_uart: CPU register accesses, serial TX capture and RX
// frame generation at CLK_DIV=16, BASE_ADDR=0.
module tb_io_uart;

  localparam int CLK_DIV = 16;
  localparam int FRAME   = 10 * CLK_DIV;

  logic       i_clk       = 1'b0;
  logic       i_resetN    = 1'b0;
  logic       i_ioSelect  = 1'b0;
  logic [7:0] i_ioAddress = 8'h00;
  logic       i_ioNOE     = 1'b1;
  logic       i_ioNWE     = 1'b1;
  logic [7:0] i_bus       = 8'h00;
  logic       i_rx        = 1'b1;
  logic [7:0] o_bus;
  logic       o_busNOE;
  logic       o_tx;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_got_q[$];
  int         tx_start_q[$];
  int         tx_bad_q[$];

  io_uart #(.BASE_ADDR(8'h00), .CLK_DIV(CLK_DIV), .FIFO_AW(3)) dut (
    .i_clk       (i_clk),
    .i_resetN    (i_resetN),
    .i_ioSelect  (i_ioSelect),
    .i_ioAddress (i_ioAddress),
    .i_ioNOE     (i_ioNOE),
    .i_ioNWE     (i_ioNWE),
    .i_bus       (i_bus),
    .o_bus       (o_bus),
    .o_busNOE    (o_busNOE),
    .i_rx        (i_rx),
    .o_tx        (o_tx)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time budget exhausted, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_read(input logic [7:0] addr, output logic [7:0] data, output logic noe);
    @(negedge i_clk);
    i_ioSelect = 1'b1; i_ioAddress = addr; i_ioNOE = 1'b0;
    #1 data = o_bus; noe = o_busNOE;
    @(negedge i_clk);
    i_ioSelect = 1'b0; i_ioNOE = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    logic       n;
    cpu_read(addr, d, n);
    check_val(tag, 32'(d), 32'(exp));
    check_val({tag, "_noe"}, 32'(n), 32'd0);
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data, output int edge_cyc);
    @(negedge i_clk);
    i_ioSelect = 1'b1; i_ioAddress = addr; i_bus = data; i_ioNWE = 1'b0;
    @(negedge i_clk);
    edge_cyc = cyc;
    i_ioSelect = 1'b0; i_ioNWE = 1'b1;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    @(negedge i_clk);
    i_rx = 1'b0;
    repeat (CLK_DIV) @(negedge i_clk);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      repeat (CLK_DIV) @(negedge i_clk);
    end
    i_rx = stop_bit;
    repeat (CLK_DIV) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (4) @(negedge i_clk);
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    int waited = 0;
    while (tx_got_q.size() < n && waited < budget) begin
      @(negedge i_clk);
      waited++;
    end
    check_val({tag, "_frame_count"}, 32'(tx_got_q.size()), 32'(n));
  endtask

  // ---------------- TX line monitor ----------------
  logic [FRAME-1:0] mon_s;
  logic [7:0]       mon_d;
  int               mon_start, mon_bad, mon_k;
  logic             mon_abort, mon_exp;

  initial begin
    forever begin
      @(negedge i_clk);
      if (i_resetN && o_tx === 1'b0) begin
        mon_start = cyc;
        mon_abort = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
          if (c > 0) @(negedge i_clk);
          if (!i_resetN) begin
            mon_abort = 1'b1;
            break;
          end
          mon_s[c] = o_tx;
        end
        if (!mon_abort) begin
          for (int k = 0; k < 8; k++) mon_d[k] = mon_s[CLK_DIV + CLK_DIV * k + CLK_DIV / 2];
          mon_bad = 0;
          for (int c = 0; c < FRAME; c++) begin
            mon_k = (c - CLK_DIV) / CLK_DIV;
            if (c < CLK_DIV) mon_exp = 1'b0;
            else if (c >= 9 * CLK_DIV) mon_exp = 1'b1;
            else mon_exp = mon_d[mon_k[2:0]];
            if (mon_s[c] !== mon_exp) mon_bad++;
          end
          tx_got_q.push_back(mon_d);
          tx_start_q.push_back(mon_start);
          tx_bad_q.push_back(mon_bad);
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check_tx_frames(input string tag, input int first_wr, input int n);
    int prev_start = 0;
    int st, bad;
    logic [7:0] got, exp;
    for (int i = 0; i < n && tx_got_q.size() > 0 && tx_exp_q.size() > 0; i++) begin
      got = tx_got_q.pop_front();
      st  = tx_start_q.pop_front();
      bad = tx_bad_q.pop_front();
      exp = tx_exp_q.pop_front();
      check_val($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(exp));
      check_val($sformatf("%s_shape%0d", tag, i), 32'(bad), 32'd0);
      if (i == 0) check_val($sformatf("%s_latency", tag), 32'(st - first_wr), 32'd2);
      else        check_val($sformatf("%s_gap%0d", tag, i), 32'(st - prev_start), 32'(FRAME));
      prev_start = st;
    end
  endtask

  task automatic read_rx_check(input string tag);
    logic [7:0] d;
    logic       n;
    logic [7:0] exp;
    exp = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'h00;
    cpu_read(8'h00, d, n);
    check_val(tag, 32'(d), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] t3_bytes [9]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
  logic [7:0] t5_bytes [10] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h7E, 8'h81, 8'h24, 8'hEE};

  initial begin
    int wc, wc0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check_val("rst_tx", 32'(o_tx), 32'd1);
    check_val("rst_busnoe", 32'(o_busNOE), 32'd1);
    check_val("rst_bus", 32'(o_bus), 32'd0);
    i_resetN = 1'b1;
    repeat (2) @(negedge i_clk);
    read_check("rst_status", 8'h01, 8'h08);
    read_check("rst_data_empty", 8'h00, 8'h00);

    // T1: single TX frame 0xA5
    tx_exp_q.push_back(8'hA5);
    cpu_write(8'h00, 8'hA5, wc);
    check_val("t1_tx_idle_after_write", 32'(o_tx), 32'd1);
    read_check("t1_status_busy", 8'h01, 8'h00);
    wait_tx("t1", 1, 400);
    check_tx_frames("t1", wc, 1);
    read_check("t1_status_idle", 8'h01, 8'h08);
    check_val("t1_tx_high_after", 32'(o_tx), 32'd1);

    // T2: receive 0x3C
    rx_exp_q.push_back(8'h3C);
    uart_send(8'h3C, 1'b1);
    read_check("t2_status_rxav", 8'h01, 8'h09);
    read_rx_check("t2_data");
    read_check("t2_status_after", 8'h01, 8'h08);

    // T3: nine frames into an eight-deep FIFO
    for (int i = 0; i < 9; i++) begin
      if (i < 8) rx_exp_q.push_back(t3_bytes[i]);
      uart_send(t3_bytes[i], 1'b1);
    end
    read_check("t3_status_ovr", 8'h01, 8'h0D);
    for (int i = 0; i < 8; i++) read_rx_check($sformatf("t3_data%0d", i));
    read_check("t3_status_after", 8'h01, 8'h08);
    read_check("t3_data_empty", 8'h00, 8'h00);

    // T4: glitch reject, then framing error
    @(negedge i_clk);
    i_rx = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (40) @(negedge i_clk);
    read_check("t4_status_glitch", 8'h01, 8'h08);
    uart_send(8'h55, 1'b0);
    read_check("t4_status_ferr", 8'h01, 8'h18);
    read_check("t4_status_cleared", 8'h01, 8'h08);

    // T5: ten back-to-back writes, only nine fit
    for (int i = 0; i < 9; i++) tx_exp_q.push_back(t5_bytes[i]);
    @(negedge i_clk);
    i_ioSelect = 1'b1; i_ioAddress = 8'h00; i_ioNWE = 1'b0; i_bus = t5_bytes[0];
    for (int i = 1; i < 9; i++) begin
      @(negedge i_clk);
      if (i == 1) wc0 = cyc;
      i_bus = t5_bytes[i];
    end
    @(negedge i_clk);
    i_ioNWE = 1'b1; i_ioAddress = 8'h01; i_ioNOE = 1'b0;
    #1 check_val("t5_txfull_after_9", 32'(o_bus), 32'h02);
    @(negedge i_clk);
    i_ioNOE = 1'b1; i_ioAddress = 8'h00; i_ioNWE = 1'b0; i_bus = t5_bytes[9];
    @(negedge i_clk);
    i_ioSelect = 1'b0; i_ioNWE = 1'b1;
    read_check("t5_txfull_after_10", 8'h01, 8'h02);
    @(negedge i_clk);
    i_ioSelect = 1'b0; i_ioAddress = 8'h01; i_ioNOE = 1'b0;
    #1 check_val("t5_unselected_noe", 32'(o_busNOE), 32'd1);
    check_val("t5_unselected_bus", 32'(o_bus), 32'd0);
    @(negedge i_clk);
    i_ioSelect = 1'b1; i_ioAddress = 8'h07;
    #1 check_val("t5_other_addr_noe", 32'(o_busNOE), 32'd1);
    @(negedge i_clk);
    i_ioSelect = 1'b0; i_ioNOE = 1'b1;
    wait_tx("t5", 9, 9 * FRAME + 300);
    repeat (200) @(negedge i_clk);
    check_val("t5_no_tenth_frame", 32'(tx_got_q.size()), 32'd9);
    check_tx_frames("t5", wc0, 9);
    read_check("t5_status_idle", 8'h01, 8'h08);

    // T6: reset in the middle of a frame
    cpu_write(8'h00, 8'h00, wc);
    cpu_write(8'h00, 8'hF0, wc);
    repeat (40) @(negedge i_clk);
    check_val("t6_tx_low_mid_frame", 32'(o_tx), 32'd0);
    #2 i_resetN = 1'b0;
    #1 check_val("t6_tx_async_high", 32'(o_tx), 32'd1);
    repeat (3) @(negedge i_clk);
    i_resetN = 1'b1;
    repeat (2) @(negedge i_clk);
    read_check("t6_status_after", 8'h01, 8'h08);
    repeat (400) @(negedge i_clk);
    check_val("t6_no_frames", 32'(tx_got_q.size()), 32'd0);
    check_val("t6_tx_idle", 32'(o_tx), 32'd1);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
